multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multicycle RV32I datapath: sequences fetch, decode, address/execute, memory and writeback steps across several clock cycles, sharing one ALU and one unified memory port. It sits between the instruction register (opcode, ALU Zero flag) and the datapath muxes and write enables. Its single-cycle counterpart is the combinational main decoder.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- Op  input  7  opcode field of the instruction register
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register write enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrt  output  1  data memory write enable
- IRWrite  output  1  instruction register and OldPC write enable
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = register A
- ALUSrcB  output  2  ALU B mux: 00 = register B, 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  to the ALU decoder: 00 = add, 01 = subtract (branch), 10 = funct-decoded
- RegWrt  output  1  register file write enable
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- Illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
- InstrDone  output  1  one-cycle pulse in the last cycle of each retired instruction

## Operation
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type
  - 0010011 I-type ALU
  - 1100011 beq
  - 1101111 jal
- States and transitions:
  - FETCH → DECODE
  - DECODE → MEMADR for lw/sw
  - DECODE → EXECR for R-type
  - DECODE → EXECI for I-type ALU
  - DECODE → BEQ for beq
  - DECODE → JAL for jal
  - DECODE → FETCH for any other opcode
  - MEMADR → MEMREAD for lw, → MEMWRITE for sw
  - MEMREAD → MEMWB
  - EXECR, EXECI and JAL → ALUWB
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH
- Moore outputs per state (any output not listed is 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut); Illegal=1 if opcode unsupported
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegWrt=1, InstrDone=1
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrt=1, InstrDone=1
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: ResultSrc=00, RegWrt=1, InstrDone=1
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, InstrDone=1
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1
- Mealy outputs:
  - PCWrite in BEQ is Zero.
  - ImmSrc is decoded combinationally from Op in every state: sw → 01, beq → 10, jal → 11, otherwise 00.
- State is encoded in 4 bits. Encodings not used by any state return to FETCH on the next edge with all enables 0.

## Timing
- Reset: when rst is sampled high, state becomes FETCH on that edge. While rst is high, PCWrite, IRWrite, MemWrt and RegWrt are forced to 0, and Illegal and InstrDone are forced to 0.
- The first cycle after rst deasserts is FETCH.
- Latency in cycles, FETCH through the last state inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
  - illegal opcode 2
- Op is only consumed in DECODE and later states. In FETCH, ImmSrc follows the stale Op; this is don't-care.
- Reset asserted mid-instruction abandons it: no further write enable asserts, and the next state is FETCH.
- Zero is sampled combinationally only in BEQ; it has no effect in other states.

## Test plan
- Reset: hold rst=1 for 3 cycles with Op=0000011 → all write enables 0 during reset; the cycle after release shows IRWrite=1, PCWrite=1, AdrSrc=0.
- lw (Op=0000011): 5 cycles, states FETCH, DECODE, MEMADR, MEMREAD, MEMWB → AdrSrc=1 in cycle 4; RegWrt=1, ResultSrc=01 and InstrDone=1 in cycle 5 only.
- sw (Op=0100011): 4 cycles → MemWrt=1 only in cycle 4; ImmSrc=01 throughout; RegWrt never asserts.
- R-type then I-type (Op=0110011, then 0010011): each takes 4 cycles, with ALUOp=10 in cycle 3. ALUSrcB=00 for R-type, 01 for I-type. RegWrt=1 in cycle 4.
- beq (Op=1100011): with Zero=1, PCWrite=1 in cycle 3; with Zero=0, PCWrite=0 in cycle 3. ALUOp=01 and ImmSrc=10 in both cases.
- jal (Op=1101111): PCWrite=1 in cycle 3 and RegWrt=1 in cycle 4. Illegal opcode Op=1111111: Illegal=1 in cycle 2, then FETCH in cycle 3 with no RegWrt or MemWrt.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle RV32I datapath. It steps each instruction
//   through fetch, decode, address/execute, memory and writeback. The steps
//   share one ALU and one unified memory port.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        synchronous, active-high reset
//   Op[6:0]    opcode field of the instruction register
//   Zero       ALU zero flag (only looked at in BEQ)
//   PCWrite    PC register write enable
//   AdrSrc     memory address select: 0 = PC, 1 = ALUOut
//   MemWrt     data memory write enable
//   IRWrite    instruction register / OldPC write enable
//   ResultSrc  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA    ALU A mux: 00 = PC, 01 = OldPC, 10 = register A
//   ALUSrcB    ALU B mux: 00 = register B, 01 = ImmExt, 10 = constant 4
//   ALUOp      ALU decoder control: 00 add, 01 subtract, 10 funct-decoded
//   RegWrt     register file write enable
//   ImmSrc     immediate format: 00 I, 01 S, 10 B, 11 J
//   Illegal    one-cycle pulse in DECODE for an unsupported opcode
//   InstrDone  one-cycle pulse in the last cycle of a retired instruction
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrt,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrt,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic       InstrDone
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] stateReg;
  logic [3:0] stateNext;
  logic       opSupported;

  assign opSupported = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_R) ||
                       (Op == OP_I)  || (Op == OP_BEQ) || (Op == OP_JAL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= FETCH;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = FETCH;
    case (stateReg)
      FETCH:  stateNext = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_R:         stateNext = EXECR;
          OP_I:         stateNext = EXECI;
          OP_BEQ:       stateNext = BEQ;
          OP_JAL:       stateNext = JAL;
          default:      stateNext = FETCH;
        endcase
      end
      MEMADR:   stateNext = (Op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  stateNext = MEMWB;
      EXECR,
      EXECI,
      JAL:      stateNext = ALUWB;
      MEMWB,
      MEMWRITE,
      ALUWB,
      BEQ:      stateNext = FETCH;
      // Unused encodings fall back to FETCH.
      default:  stateNext = FETCH;
    endcase
  end

  // Output logic. The write enables and pulses are gated by rst. This keeps
  // an instruction interrupted by reset from writing anything further.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrt    = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrt    = 1'b0;
    Illegal   = 1'b0;
    InstrDone = 1'b0;
    case (stateReg)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        Illegal = ~opSupported;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrt    = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrt    = 1'b1;
        InstrDone = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrt    = 1'b1;
        InstrDone = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: begin
      end
    endcase
    if (rst) begin
      PCWrite   = 1'b0;
      MemWrt    = 1'b0;
      IRWrite   = 1'b0;
      RegWrt    = 1'b0;
      Illegal   = 1'b0;
      InstrDone = 1'b0;
    end
  end

  // The immediate format is decoded from the opcode in every state.
  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule
